ex_stage_md: RTL and testbench
==============================

Name: ex_stage_md

Overview:
Registered, handshaked execute stage that adds RV32M multiply/divide to the single-cycle ALU execute path.
- ALU ops complete in one cycle.
- MUL*/DIV*/REM* run on an iterative shift-add / restoring-divide datapath with a cycle counter.
- Sits between decode and memory stages, using a valid/ready handshake on both sides and a flush input for branch/trap kill.
- Operand B selection (register vs immediate) and sideband propagation (rd, rf_en, dm_en, wb_sel) match the existing execute stage.

Parameters:
DATA_WIDTH, 32, operand/result width (even, >=8)
RF_ADDR_W, 5, destination register index width
WB_SEL_W, 2, writeback-select field width
EARLY_OUT, 1, 1 = divide-by-zero and signed-overflow results complete in 1 cycle; 0 = full iteration

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
valid_i  in  1  upstream op valid
ready_o  out  1  stage can accept op
flush_i  in  1  kill in-flight op and pending result
aluop_i  in  ALUOP_W (alu_pkg)  ALU operation
md_en_i  in  1  1 = mul/div op, mdop_i used, aluop_i ignored
mdop_i  in  3  mdop_t, funct3 order MUL,MULH,MULHSU,MULHU,DIV,DIVU,REM,REMU
opr_a_i  in  DATA_WIDTH  operand A
opr_b_i  in  DATA_WIDTH  operand B (register)
imm_i  in  DATA_WIDTH  immediate
opr_b_sel_i  in  1  1 = imm_i as operand B (ALU ops only; mul/div always use opr_b_i)
rd_i  in  RF_ADDR_W  destination register
rf_en_i  in  1  register-file write enable
dm_en_i  in  1  data-memory enable
wb_sel_i  in  WB_SEL_W  writeback select
valid_o  out  1  result valid
ready_i  in  1  downstream accepts result
opr_res_o  out  DATA_WIDTH  result
opr_b_o  out  DATA_WIDTH  store data (registered opr_b_i)
rd_o, rf_en_o, dm_en_o, wb_sel_o  out  as inputs  registered sideband

Behaviour:
- Reset: state IDLE, counter 0, valid_o 0, opr_res_o/opr_b_o/rd_o/wb_sel_o 0, rf_en_o 0, dm_en_o 0.
- Handshake:
  - accept = valid_i && ready_o && !flush_i.
  - ready_o = (state==IDLE) && (!valid_o || ready_i); combinational, no dependency on valid_i.
  - Output: when valid_o && !ready_i, all outputs hold stable.
  - A transfer occurs on valid_o && ready_i; valid_o drops unless a new result loads the same cycle.
- FSM IDLE/BUSY:
  - IDLE, accept of an ALU op: load result = alu(opr_a, opr_b_sel ? imm : opr_b) and sideband; valid_o=1 next cycle (latency 1).
  - IDLE, accept of a mul/div op: latch operands and sideband, counter=0, go to BUSY.
  - BUSY: one shift-add or restore step per cycle. After DATA_WIDTH steps, load result, valid_o=1, go to IDLE. Latency DATA_WIDTH+1 from accept to valid_o.
  - ready_o=0 throughout BUSY.
- Arithmetic:
  - Signed ops take operand magnitudes; sign is fixed up at completion.
  - MUL returns low half of the 2*DATA_WIDTH product; MULH/MULHSU/MULHU return the high half with signed×signed, signed×unsigned, and unsigned×unsigned semantics respectively.
  - DIV/REM truncate toward zero; remainder takes the dividend's sign.
- Boundary results (RISC-V defined):
  - Divisor 0: DIV/DIVU quotient = all ones; REM/REMU result = dividend.
  - Signed overflow (dividend = most-negative value, divisor = -1): DIV result = dividend; REM result = 0.
  - With EARLY_OUT=1, both cases skip BUSY and complete with latency 1.
- Flush:
  - Asynchronous to op progress, synchronous to clk. Next edge: state IDLE, counter 0, valid_o 0, rf_en_o 0, dm_en_o 0.
  - Flush wins over a same-cycle accept and a same-cycle output transfer; the downstream must ignore valid_o in a cycle where flush_i is high.
- Reset mid-BUSY returns immediately to the reset values.

Decomposition:
- ex_stage_md_pkg: mdop_t enum (3-bit, funct3 values), md_state_t {IDLE, BUSY}, counter width $clog2(DATA_WIDTH+1), helper functions is_signed_a/is_signed_b/is_div.
- Reuse the existing alu module for ALU ops.
- One sub-module, md_unit: iterative multiply/divide core with start/done, operands, mdop, result, and flush.
- ex_stage_md holds the handshake, the output register, and operand-B select.

Test Plan:
- ADD via imm (opr_a=5, imm=7, opr_b_sel=1), ready_i=1 -> valid_o 1 cycle after accept, opr_res_o=12, rd/wb_sel propagated.
- ADD 5+7 with ready_i low for 3 cycles -> opr_res_o holds 12, ready_o=0 and no new op accepted until the transfer.
- DIV 20/-3 and REM 20/-3 (DATA_WIDTH=32) -> 0xFFFFFFFA and 0x00000002; valid_o exactly 33 cycles after accept, ready_o low in between.
- MULH 0x80000000×0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE; MUL same operands -> 0x00000001.
- DIVU 123/0 -> 0xFFFFFFFF, REM 0x80000000/-1 -> 0, DIV 0x80000000/-1 -> 0x80000000; each with latency 1 when EARLY_OUT=1, 33 when EARLY_OUT=0.
- Flush 10 cycles into a DIV, plus flush_i and valid_i high together -> valid_o never asserts for the killed op, ready_o=1 next cycle, flushed-cycle op not accepted.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - ALU operation encoding shared by decode and execute
package alu_pkg;
  localparam int ALUOP_W = 4;

  typedef enum logic [ALUOP_W-1:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_SLL    = 4'd2,
    ALU_SLT    = 4'd3,
    ALU_SLTU   = 4'd4,
    ALU_XOR    = 4'd5,
    ALU_SRL    = 4'd6,
    ALU_SRA    = 4'd7,
    ALU_OR     = 4'd8,
    ALU_AND    = 4'd9,
    ALU_PASS_B = 4'd10
  } aluop_t;
endpackage

// File: rtl/ex_stage_md_pkg.sv
// rtl/ex_stage_md_pkg.sv - mul/div op encoding, state type and op classification helpers
package ex_stage_md_pkg;
  typedef enum logic [2:0] {
    MD_MUL    = 3'd0,
    MD_MULH   = 3'd1,
    MD_MULHSU = 3'd2,
    MD_MULHU  = 3'd3,
    MD_DIV    = 3'd4,
    MD_DIVU   = 3'd5,
    MD_REM    = 3'd6,
    MD_REMU   = 3'd7
  } mdop_t;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} md_state_t;

  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

  function automatic logic is_signed_a(input mdop_t op);
    return (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM);
  endfunction

  function automatic logic is_signed_b(input mdop_t op);
    return (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
  endfunction

  function automatic logic is_div(input mdop_t op);
    return op[2];
  endfunction
endpackage

// File: rtl/alu.sv
// rtl/alu.sv - single-cycle combinational integer ALU
module alu
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  aluop_t                op,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] res
);
  localparam int SH_W = $clog2(DATA_WIDTH);

  logic [SH_W-1:0] shamt;
  assign shamt = b[SH_W-1:0];

  always_comb begin
    res = '0;
    case (op)
      ALU_ADD:    res = a + b;
      ALU_SUB:    res = a - b;
      ALU_SLL:    res = a << shamt;
      ALU_SLT:    res = DATA_WIDTH'($signed(a) < $signed(b));
      ALU_SLTU:   res = DATA_WIDTH'(a < b);
      ALU_XOR:    res = a ^ b;
      ALU_SRL:    res = a >> shamt;
      ALU_SRA:    res = $signed(a) >>> shamt;
      ALU_OR:     res = a | b;
      ALU_AND:    res = a & b;
      ALU_PASS_B: res = b;
      default:    res = '0;
    endcase
  end
endmodule

// File: rtl/ex_stage_md_md_unit.sv
// rtl/ex_stage_md_md_unit.sv - iterative shift-add multiplier / restoring divider on operand magnitudes
module md_unit
  import ex_stage_md_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  start,
  input  mdop_t                 op,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  special_hit,
  output logic [DATA_WIDTH-1:0] special_res
);
  localparam int W     = DATA_WIDTH;
  localparam int CNT_W = cnt_width(W);
  localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

  md_state_t        state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [W-1:0]     hi, lo, opd, spec_res_q;
  mdop_t            op_q;
  logic             neg_q, neg_r, spec_q;

  logic             a_neg, b_neg;
  logic [W-1:0]     a_mag, b_mag;
  logic [W:0]       mul_sum, div_sh;
  logic             div_ge;
  logic [W-1:0]     step_hi, step_lo;
  logic [2*W-1:0]   prod;

  assign a_neg = is_signed_a(op) && a[W-1];
  assign b_neg = is_signed_b(op) && b[W-1];
  assign a_mag = a_neg ? -a : a;
  assign b_mag = b_neg ? -b : b;
  assign busy  = (state == BUSY);

  // Divide-by-zero and signed overflow have architecturally fixed results
  always_comb begin
    special_hit = 1'b0;
    special_res = '0;
    if (is_div(op)) begin
      if (b == '0) begin
        special_hit = 1'b1;
        special_res = op[1] ? a : '1;
      end else if (is_signed_a(op) && (a == MIN_NEG) && (b == '1)) begin
        special_hit = 1'b1;
        special_res = op[1] ? '0 : a;
      end
    end
  end

  always_comb begin
    mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, opd} : '0);
    div_sh  = {hi, lo[W-1]};
    div_ge  = (div_sh >= {1'b0, opd});
    if (is_div(op_q)) begin
      step_hi = div_ge ? (div_sh[W-1:0] - opd) : div_sh[W-1:0];
      step_lo = {lo[W-2:0], div_ge};
    end else begin
      step_hi = mul_sum[W:1];
      step_lo = {mul_sum[0], lo[W-1:1]};
    end
  end

  // Result is taken from the final step's next value so the last step costs no extra cycle
  always_comb begin
    prod = {step_hi, step_lo};
    if (neg_q) prod = -prod;
    case (op_q)
      MD_MUL:                       result = prod[W-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: result = prod[2*W-1:W];
      MD_DIV, MD_DIVU:              result = neg_q ? -step_lo : step_lo;
      default:                      result = neg_r ? -step_hi : step_hi;
    endcase
    if (spec_q) result = spec_res_q;
  end

  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = BUSY;
      BUSY: if (cnt == CNT_W'(W - 1)) begin
        done      = !flush;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      hi         <= '0;
      lo         <= '0;
      opd        <= '0;
      op_q       <= MD_MUL;
      neg_q      <= 1'b0;
      neg_r      <= 1'b0;
      spec_q     <= 1'b0;
      spec_res_q <= '0;
    end else if (flush) begin
      cnt <= '0;
    end else if (state == IDLE) begin
      cnt <= '0;
      if (start) begin
        hi         <= '0;
        lo         <= is_div(op) ? a_mag : b_mag;
        opd        <= is_div(op) ? b_mag : a_mag;
        op_q       <= op;
        neg_q      <= a_neg ^ b_neg;
        neg_r      <= a_neg;
        spec_q     <= special_hit;
        spec_res_q <= special_res;
      end
    end else begin
      hi  <= step_hi;
      lo  <= step_lo;
      cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/ex_stage_md.sv
// rtl/ex_stage_md.sv - handshaked execute stage: single-cycle ALU plus iterative RV32M mul/div
module ex_stage_md
  import alu_pkg::*;
  import ex_stage_md_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int RF_ADDR_W  = 5,
  parameter int WB_SEL_W   = 2,
  parameter int EARLY_OUT  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic                  flush_i,
  input  aluop_t                aluop_i,
  input  logic                  md_en_i,
  input  logic [2:0]            mdop_i,
  input  logic [DATA_WIDTH-1:0] opr_a_i,
  input  logic [DATA_WIDTH-1:0] opr_b_i,
  input  logic [DATA_WIDTH-1:0] imm_i,
  input  logic                  opr_b_sel_i,
  input  logic [RF_ADDR_W-1:0]  rd_i,
  input  logic                  rf_en_i,
  input  logic                  dm_en_i,
  input  logic [WB_SEL_W-1:0]   wb_sel_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [DATA_WIDTH-1:0] opr_res_o,
  output logic [DATA_WIDTH-1:0] opr_b_o,
  output logic [RF_ADDR_W-1:0]  rd_o,
  output logic                  rf_en_o,
  output logic                  dm_en_o,
  output logic [WB_SEL_W-1:0]   wb_sel_o
);
  logic [DATA_WIDTH-1:0] opr_b_mux, alu_res, md_res, md_special_res, now_res;
  logic                  md_busy, md_done, md_special_hit;
  logic                  accept, early, md_start, load_now;

  logic [DATA_WIDTH-1:0] pend_b;
  logic [RF_ADDR_W-1:0]  pend_rd;
  logic                  pend_rf, pend_dm;
  logic [WB_SEL_W-1:0]   pend_wb;

  assign opr_b_mux = opr_b_sel_i ? imm_i : opr_b_i;
  assign ready_o   = !md_busy && (!valid_o || ready_i);
  assign accept    = valid_i && ready_o && !flush_i;
  assign early     = (EARLY_OUT != 0) && md_special_hit;
  assign md_start  = accept && md_en_i && !early;
  assign load_now  = accept && (!md_en_i || early);
  assign now_res   = md_en_i ? md_special_res : alu_res;

  alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
    .op  (aluop_i),
    .a   (opr_a_i),
    .b   (opr_b_mux),
    .res (alu_res)
  );

  md_unit #(.DATA_WIDTH(DATA_WIDTH)) u_md (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush_i),
    .start       (md_start),
    .op          (mdop_t'(mdop_i)),
    .a           (opr_a_i),
    .b           (opr_b_i),
    .busy        (md_busy),
    .done        (md_done),
    .result      (md_res),
    .special_hit (md_special_hit),
    .special_res (md_special_res)
  );

  // Sideband waits here while the iterative op runs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_b  <= '0;
      pend_rd <= '0;
      pend_rf <= 1'b0;
      pend_dm <= 1'b0;
      pend_wb <= '0;
    end else if (md_start) begin
      pend_b  <= opr_b_i;
      pend_rd <= rd_i;
      pend_rf <= rf_en_i;
      pend_dm <= dm_en_i;
      pend_wb <= wb_sel_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_o   <= 1'b0;
      opr_res_o <= '0;
      opr_b_o   <= '0;
      rd_o      <= '0;
      rf_en_o   <= 1'b0;
      dm_en_o   <= 1'b0;
      wb_sel_o  <= '0;
    end else if (flush_i) begin
      valid_o <= 1'b0;
      rf_en_o <= 1'b0;
      dm_en_o <= 1'b0;
    end else if (load_now) begin
      valid_o   <= 1'b1;
      opr_res_o <= now_res;
      opr_b_o   <= opr_b_i;
      rd_o      <= rd_i;
      rf_en_o   <= rf_en_i;
      dm_en_o   <= dm_en_i;
      wb_sel_o  <= wb_sel_i;
    end else if (md_done) begin
      valid_o   <= 1'b1;
      opr_res_o <= md_res;
      opr_b_o   <= pend_b;
      rd_o      <= pend_rd;
      rf_en_o   <= pend_rf;
      dm_en_o   <= pend_dm;
      wb_sel_o  <= pend_wb;
    end else if (valid_o && ready_i) begin
      valid_o <= 1'b0;
    end
  end
endmodule

// File: tb/tb_ex_stage_md.sv
// tb/tb_ex_stage_md.sv - scoreboard bench for ex_stage_md
module tb_ex_stage_md;
  import alu_pkg::*;
  import ex_stage_md_pkg::*;

  localparam int W     = 32;
  localparam int EARLY = 1;
  localparam int MDL   = W + 1;
  localparam int SPL   = (EARLY != 0) ? 1 : W + 1;

  logic        clk = 1'b0, rst = 1'b1;
  logic        valid_i = 1'b0, flush_i = 1'b0, md_en_i = 1'b0, opr_b_sel_i = 1'b0;
  logic        rf_en_i = 1'b0, dm_en_i = 1'b0, ready_i = 1'b1;
  aluop_t      aluop_i = ALU_ADD;
  logic [2:0]  mdop_i = 3'd0;
  logic [W-1:0] opr_a_i = '0, opr_b_i = '0, imm_i = '0;
  logic [4:0]  rd_i = '0;
  logic [1:0]  wb_sel_i = '0;
  logic        ready_o, valid_o, rf_en_o, dm_en_o;
  logic [W-1:0] opr_res_o, opr_b_o;
  logic [4:0]  rd_o;
  logic [1:0]  wb_sel_o;

  ex_stage_md #(.DATA_WIDTH(W), .RF_ADDR_W(5), .WB_SEL_W(2), .EARLY_OUT(EARLY)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_o), .flush_i(flush_i),
    .aluop_i(aluop_i), .md_en_i(md_en_i), .mdop_i(mdop_i), .opr_a_i(opr_a_i),
    .opr_b_i(opr_b_i), .imm_i(imm_i), .opr_b_sel_i(opr_b_sel_i), .rd_i(rd_i),
    .rf_en_i(rf_en_i), .dm_en_i(dm_en_i), .wb_sel_i(wb_sel_i), .valid_o(valid_o),
    .ready_i(ready_i), .opr_res_o(opr_res_o), .opr_b_o(opr_b_o), .rd_o(rd_o),
    .rf_en_o(rf_en_o), .dm_en_o(dm_en_o), .wb_sel_o(wb_sel_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] res;
    logic [W-1:0] b;
    logic [4:0]   rd;
    logic [1:0]   wb;
    logic         rf;
    logic         dm;
    int           lat;
    int           stamp;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0, errors = 0;
  bit   seen_v = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: latency on first valid, contents on transfer
  always @(negedge clk) begin
    if (!rst && valid_o && !flush_i) begin
      if (sbq.size() == 0) begin
        if (!seen_v) chk("stray_valid", valid_o, 1'b0);
        seen_v = !ready_i;
      end else begin
        if (!seen_v) begin
          chk("latency", cyc - sbq[0].stamp, sbq[0].lat);
          seen_v = 1'b1;
        end
        if (ready_i) begin
          chk("result", opr_res_o, sbq[0].res);
          chk("store_data", opr_b_o, sbq[0].b);
          chk("sideband", {rd_o, wb_sel_o, rf_en_o, dm_en_o},
              {sbq[0].rd, sbq[0].wb, sbq[0].rf, sbq[0].dm});
          void'(sbq.pop_front());
          seen_v = 1'b0;
        end
      end
    end
  end

  task automatic set_op(input logic md, input logic [2:0] mop, input aluop_t aop,
                        input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] imm,
                        input logic bsel, input logic [4:0] rd, input logic [1:0] wb);
    md_en_i = md; mdop_i = mop; aluop_i = aop; opr_a_i = a; opr_b_i = b; imm_i = imm;
    opr_b_sel_i = bsel; rd_i = rd; wb_sel_i = wb; rf_en_i = 1'b1; dm_en_i = rd[0];
    valid_i = 1'b1;
  endtask

  task automatic push_exp(input logic [W-1:0] res, input int lat);
    exp_t e;
    e.res = res; e.b = opr_b_i; e.rd = rd_i; e.wb = wb_sel_i; e.rf = rf_en_i;
    e.dm = dm_en_i; e.lat = lat; e.stamp = cyc;
    sbq.push_back(e);
  endtask

  // Drive an op from posedge+1, push its expectation in the accept cycle
  task automatic drive_op(input logic md, input logic [2:0] mop, input aluop_t aop,
                          input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] imm,
                          input logic bsel, input logic [4:0] rd, input logic [1:0] wb,
                          input logic [W-1:0] res, input int lat, input bit expect_it);
    int n;
    @(posedge clk); #1;
    set_op(md, mop, aop, a, b, imm, bsel, rd, wb);
    n = 0;
    @(negedge clk);
    while (!ready_o && n < 200) begin @(negedge clk); n++; end
    if (!ready_o) chk("accept_timeout", ready_o, 1'b1);
    if (expect_it) push_exp(res, lat);
    @(posedge clk); #1;
    valid_i = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((sbq.size() != 0 || valid_o) && n < 300) begin @(negedge clk); n++; end
    if (n >= 300) chk("drain_timeout", sbq.size(), 0);
  endtask

  task automatic run_md(input mdop_t mop, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] res, input int lat, input logic [4:0] rd);
    int n, bad;
    drive_op(1'b1, mop, ALU_ADD, a, b, 32'h0, 1'b0, rd, 2'd1, res, lat, 1'b1);
    n = 0; bad = 0;
    while (n < 100) begin
      @(negedge clk);
      n++;
      if (valid_o) break;
      if (ready_o) bad++;
    end
    if (!valid_o) chk("md_timeout", valid_o, 1'b1);
    chk("busy_ready_low", bad, 0);
    wait_idle();
  endtask

  initial begin
    int vcount;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", valid_o, 1'b0);
    chk("rst_res", opr_res_o, 32'h0);
    chk("rst_b", opr_b_o, 32'h0);
    chk("rst_side", {rd_o, wb_sel_o, rf_en_o, dm_en_o}, 9'h0);
    chk("rst_ready", ready_o, 1'b1);

    drive_op(1'b0, 3'd0, ALU_ADD, 32'd5, 32'h55, 32'd7, 1'b1, 5'd9, 2'd2, 32'd12, 1, 1'b1);
    wait_idle();
    drive_op(1'b0, 3'd0, ALU_SUB, 32'd3, 32'd5, 32'd100, 1'b0, 5'd4, 2'd0, 32'hFFFFFFFE, 1, 1'b1);
    wait_idle();

    // Downstream stall: result holds and a waiting op is refused until the transfer
    ready_i = 1'b0;
    drive_op(1'b0, 3'd0, ALU_ADD, 32'd5, 32'd0, 32'd7, 1'b1, 5'd10, 2'd3, 32'd12, 1, 1'b1);
    set_op(1'b0, 3'd0, ALU_ADD, 32'd1, 32'd1, 32'd0, 1'b0, 5'd3, 2'd1);
    repeat (3) begin
      @(negedge clk);
      chk("hold_res", opr_res_o, 32'd12);
      chk("hold_valid", valid_o, 1'b1);
      chk("hold_ready", ready_o, 1'b0);
    end
    @(posedge clk); #1;
    ready_i = 1'b1;
    push_exp(32'd2, 1);
    @(posedge clk); #1;
    valid_i = 1'b0;
    wait_idle();

    run_md(MD_DIV,    32'd20,       32'hFFFFFFFD, 32'hFFFFFFFA, MDL, 5'd5);
    run_md(MD_REM,    32'd20,       32'hFFFFFFFD, 32'h00000002, MDL, 5'd6);
    run_md(MD_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, MDL, 5'd7);
    run_md(MD_MULH,   32'h80000000, 32'h80000000, 32'h40000000, MDL, 5'd8);
    run_md(MD_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, MDL, 5'd11);
    run_md(MD_MUL,    32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, MDL, 5'd12);
    run_md(MD_MULHSU, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, MDL, 5'd13);
    run_md(MD_DIVU,   32'd123,      32'd0,        32'hFFFFFFFF, SPL, 5'd14);
    run_md(MD_REMU,   32'd7,        32'd0,        32'h00000007, SPL, 5'd15);
    run_md(MD_DIV,    32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF, SPL, 5'd16);
    run_md(MD_REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, SPL, 5'd17);
    run_md(MD_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, SPL, 5'd18);

    // Flush mid-divide, then flush alongside a valid op in an idle cycle
    drive_op(1'b1, MD_DIV, ALU_ADD, 32'd1000, 32'd7, 32'd0, 1'b0, 5'd19, 2'd1, 32'd0, 0, 1'b0);
    repeat (9) @(posedge clk);
    #1;
    flush_i = 1'b1;
    @(posedge clk); #1;
    set_op(1'b0, 3'd0, ALU_ADD, 32'd9, 32'd9, 32'd0, 1'b0, 5'd20, 2'd1);
    @(negedge clk);
    chk("flush_ready", ready_o, 1'b1);
    chk("flush_valid", valid_o, 1'b0);
    chk("flush_rf_en", rf_en_o, 1'b0);
    @(posedge clk); #1;
    flush_i = 1'b0;
    valid_i = 1'b0;
    vcount = 0;
    repeat (40) begin
      @(negedge clk);
      if (valid_o) vcount++;
    end
    chk("flush_no_valid", vcount, 0);
    chk("flush_idle_ready", ready_o, 1'b1);

    drive_op(1'b0, 3'd0, ALU_XOR, 32'hF0F0F0F0, 32'h0FF00FF0, 32'd0, 1'b0, 5'd21, 2'd2,
             32'hFF00FF00, 1, 1'b1);
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout actual=%0d expected=finish", cyc);
    $fatal(1);
  end
endmodule
